pool_supervisor: RTL

POOL_SUPERVISOR -- requirements
Module: pool_supervisor

---
 rtl/shapool_pkg.sv | 22 ++
 rtl/led_blinker.sv | 45 ++++
 rtl/pool_supervisor.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/shapool_pkg.sv
// Shared definitions for the hashing-pool supervisor: state encoding,
// default clock/blink constants and a small sizing helper.
package shapool_pkg;

    typedef enum logic [1:0] {
        ST_LOCKWAIT = 2'd0,
        ST_IDLE     = 2'd1,
        ST_RUN      = 2'd2,
        ST_DONE     = 2'd3
    } state_e;

    localparam int DEFAULT_CLK_HZ   = 30_000_000;
    localparam int DEFAULT_BLINK_HZ = 2;

    // Bits needed to hold the value v itself (at least 1).
    function automatic int bits_for(input int v);
        int w;
        w = $clog2(v + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/led_blinker.sv
// Divider-and-toggle LED driver. A period of zero parks the LED dark;
// restart clears the divider and turns the LED on for the next cycle.
module led_blinker #(
    parameter int DIV_W = 3
)(
    input  logic             clk_in,
    input  logic             reset_in,
    input  logic [DIV_W-1:0] period_in,
    input  logic             restart_in,
    output logic             led_n_out
);

    logic [DIV_W-1:0] div_q, div_d;
    logic             led_n_q, led_n_d;

    always_comb begin
        div_d   = div_q;
        led_n_d = led_n_q;
        if (period_in == '0) begin
            div_d   = '0;
            led_n_d = 1'b1;
        end else if (restart_in) begin
            div_d   = '0;
            led_n_d = 1'b0;
        end else if (div_q >= period_in - DIV_W'(1)) begin
            div_d   = '0;
            led_n_d = ~led_n_q;
        end else begin
            div_d = div_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            div_q   <= '0;
            led_n_q <= 1'b1;
        end else begin
            div_q   <= div_d;
            led_n_q <= led_n_d;
        end
    end

    assign led_n_out = led_n_q;

endmodule

// File: rtl/pool_supervisor.sv
// Supervises a pool of hashing cores: waits for a qualified PLL lock,
// runs jobs, latches the lowest-index winner and drives READY and a status LED.
module pool_supervisor
    import shapool_pkg::*;
#(
    parameter int POOL_SIZE      = 2,
    parameter int POOL_SIZE_LOG2 = 1,
    parameter int CLK_HZ         = DEFAULT_CLK_HZ,
    parameter int LOCK_CYCLES    = 1024,
    parameter int BLINK_HZ       = DEFAULT_BLINK_HZ
)(
    input  logic                      clk_in,
    input  logic                      reset_in,
    input  logic                      pll_lock_in,
    input  logic                      start_in,
    input  logic                      halt_in,
    input  logic [POOL_SIZE-1:0]      found_in,
    output logic                      core_reset_out,
    output logic                      core_run_out,
    output logic                      winner_valid_out,
    output logic [POOL_SIZE_LOG2-1:0] winner_idx_out,
    output logic                      ready_n_oe_out,
    output logic                      status_led_n_out
);

    localparam int HALF      = CLK_HZ / (2 * BLINK_HZ);
    localparam int HALF_DONE = (HALF / 4 < 1) ? 1 : HALF / 4;
    localparam int DIV_W     = bits_for(HALF);
    localparam int CNT_W     = bits_for(LOCK_CYCLES);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(LOCK_CYCLES);

    if (HALF < 1) begin : g_bad_half
        $error("pool_supervisor: CLK_HZ/(2*BLINK_HZ) must be at least 1");
    end
    if (POOL_SIZE > (1 << POOL_SIZE_LOG2)) begin : g_bad_log2
        $error("pool_supervisor: POOL_SIZE_LOG2 too small for POOL_SIZE");
    end
    if (LOCK_CYCLES < 1) begin : g_bad_lock
        $error("pool_supervisor: LOCK_CYCLES must be at least 1");
    end

    state_e                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      win_valid_q, win_valid_d;
    logic [POOL_SIZE_LOG2-1:0] win_idx_q, win_idx_d;
    logic                      core_reset_q, core_reset_d;
    logic                      core_run_q, core_run_d;
    logic [POOL_SIZE_LOG2-1:0] first_idx;
    logic [DIV_W-1:0]          blink_period;
    logic                      blink_restart;

    // Lowest set bit wins: scan from the top so the lowest hit overwrites.
    always_comb begin
        first_idx = '0;
        for (int i = POOL_SIZE - 1; i >= 0; i--) begin
            if (found_in[i]) begin
                first_idx = POOL_SIZE_LOG2'(i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        win_valid_d = win_valid_q;
        win_idx_d   = win_idx_q;
        if (!pll_lock_in) begin
            state_d     = ST_LOCKWAIT;
            cnt_d       = '0;
            win_valid_d = 1'b0;
            win_idx_d   = '0;
        end else begin
            case (state_q)
                ST_LOCKWAIT: begin
                    cnt_d = (cnt_q == CNT_FULL) ? cnt_q : cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (start_in) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (halt_in) begin
                        state_d = ST_IDLE;
                    end else if (|found_in) begin
                        state_d     = ST_DONE;
                        win_valid_d = 1'b1;
                        win_idx_d   = first_idx;
                    end
                end
                ST_DONE: begin
                    if (halt_in || start_in) begin
                        state_d     = halt_in ? ST_IDLE : ST_RUN;
                        win_valid_d = 1'b0;
                        win_idx_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_LOCKWAIT;
                    cnt_d   = '0;
                end
            endcase
        end
        core_reset_d = (state_d == ST_LOCKWAIT);
        core_run_d   = (state_d == ST_RUN);
    end

    // Period follows the next state so the LED changes on the entry edge;
    // IDLE holds restart to keep the LED steadily on.
    always_comb begin
        case (state_d)
            ST_LOCKWAIT: blink_period = '0;
            ST_DONE:     blink_period = DIV_W'(HALF_DONE);
            default:     blink_period = DIV_W'(HALF);
        endcase
        blink_restart = (state_d == ST_IDLE) ||
                        ((state_d != state_q) && (state_d != ST_LOCKWAIT));
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q      <= ST_LOCKWAIT;
            cnt_q        <= '0;
            win_valid_q  <= 1'b0;
            win_idx_q    <= '0;
            core_reset_q <= 1'b1;
            core_run_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            win_valid_q  <= win_valid_d;
            win_idx_q    <= win_idx_d;
            core_reset_q <= core_reset_d;
            core_run_q   <= core_run_d;
        end
    end

    led_blinker #(
        .DIV_W (DIV_W)
    ) u_led_blinker (
        .clk_in     (clk_in),
        .reset_in   (reset_in),
        .period_in  (blink_period),
        .restart_in (blink_restart),
        .led_n_out  (status_led_n_out)
    );

    assign core_reset_out   = core_reset_q;
    assign core_run_out     = core_run_q;
    assign winner_valid_out = win_valid_q;
    assign winner_idx_out   = win_idx_q;
    assign ready_n_oe_out   = win_valid_q;

endmodule
